find_extrema: RTL and testbench

Parametrised successor to the single-channel max-finder FSM-D. It accepts a framed stream of samples and tracks, for each sequence, the running maximum, the running minimum, the index of the first maximum and the sample count. Values are signed or unsigned and the maximum sequence length is bounded. It sits between a streaming source and a consumer that samples results on `done`.

---
 rtl/find_extrema_pkg.sv | 25 ++
 rtl/extrema_cmp.sv | 36 +++
 rtl/find_extrema.sv | 99 +++++++++
 tb/tb_find_extrema.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/find_extrema_pkg.sv
// Shared types and the strict-greater compare used by both extrema paths.
package find_extrema_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operands are pre-extended to this width so one function serves any WIDTH up to 64.
  localparam int CMP_W = 64;

  function automatic logic gt(input logic [CMP_W-1:0] a,
                              input logic [CMP_W-1:0] b,
                              input logic             signed_mode);
    logic signed [CMP_W-1:0] a_s;
    logic signed [CMP_W-1:0] b_s;
    a_s = a;
    b_s = b;
    if (signed_mode)
      return a_s > b_s;
    return a > b;
  endfunction

endpackage

// File: rtl/extrema_cmp.sv
// Combinational strict-greater comparator: gt_out = (a > b) in the selected number system.
module extrema_cmp
  import find_extrema_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt_out
);

  logic [CMP_W-1:0] a_ext;
  logic [CMP_W-1:0] b_ext;

  generate
    if (SIGNED != 0) begin : g_sext
      logic signed [WIDTH-1:0] a_s;
      logic signed [WIDTH-1:0] b_s;
      always_comb begin
        a_s   = a;
        b_s   = b;
        a_ext = CMP_W'(a_s);
        b_ext = CMP_W'(b_s);
      end
    end else begin : g_zext
      always_comb begin
        a_ext = CMP_W'(a);
        b_ext = CMP_W'(b);
      end
    end
  endgenerate

  assign gt_out = gt(a_ext, b_ext, SIGNED != 0);

endmodule

// File: rtl/find_extrema.sv
// Framed-stream extrema tracker: running max/min, first-max index and sample count per sequence.
module find_extrema
  import find_extrema_pkg::*;
#(
  parameter int   WIDTH   = 8,
  parameter int   MAX_LEN = 16,
  parameter int   SIGNED  = 0,
  localparam int  IDXW    = $clog2(MAX_LEN),
  localparam int  CNTW    = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] min_val,
  output logic [IDXW-1:0]  max_idx,
  output logic [CNTW-1:0]  count,
  output logic             done
);

  state_t          state;
  state_t          next_state;
  logic            accept;
  logic            terminal;
  logic            first;
  logic            max_gt;
  logic            min_gt;
  logic [CNTW-1:0] count_inc;

  assign accept    = in_valid && in_ready;
  assign count_inc = count + CNTW'(1);
  assign terminal  = in_last || (count_inc == CNTW'(MAX_LEN));
  assign first     = (count == '0);

  extrema_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_max_cmp (
    .a      (in_data),
    .b      (max_val),
    .gt_out (max_gt)
  );

  // Min path reuses the same strict-greater test with operands swapped.
  extrema_cmp #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_min_cmp (
    .a      (min_val),
    .b      (in_data),
    .gt_out (min_gt)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (accept && terminal) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == RUN);
    done     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      max_val <= '0;
      min_val <= '0;
      max_idx <= '0;
      count   <= '0;
    end else if (accept) begin
      count <= count_inc;
      if (first) begin
        max_val <= in_data;
        min_val <= in_data;
        max_idx <= '0;
      end else begin
        if (max_gt) begin
          max_val <= in_data;
          max_idx <= count[IDXW-1:0];
        end
        if (min_gt)
          min_val <= in_data;
      end
    end else if (start && (state == IDLE || state == DONE)) begin
      count <= '0;
    end
  end

endmodule

// File: tb/tb_find_extrema.sv
// Scoreboard bench for find_extrema: unsigned, signed and short-MAX_LEN instances.
module tb_find_extrema;

  typedef struct {
    logic [7:0] mx;
    logic [7:0] mn;
    int         idx;
    int         cnt;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] in_data = '0;
  logic       m_start = 1'b0, m_valid = 1'b0, m_last = 1'b0;
  logic [7:0] m_data = '0;

  logic       u_ready, u_done, s_ready, s_done, m_ready, m_done;
  logic [7:0] u_max, u_min, s_max, s_min, m_max, m_min;
  logic [3:0] u_idx, s_idx;
  logic [4:0] u_cnt, s_cnt;
  logic [1:0] m_idx;
  logic [2:0] m_cnt;

  int   checks = 0;
  int   errors = 0;
  res_t qu[$];
  res_t qs[$];
  res_t qm[$];

  always #5 clk = ~clk;

  find_extrema #(.WIDTH(8), .MAX_LEN(16), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(u_ready), .max_val(u_max), .min_val(u_min),
    .max_idx(u_idx), .count(u_cnt), .done(u_done));

  find_extrema #(.WIDTH(8), .MAX_LEN(16), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .in_data(in_data), .in_ready(s_ready), .max_val(s_max), .min_val(s_min),
    .max_idx(s_idx), .count(s_cnt), .done(s_done));

  find_extrema #(.WIDTH(8), .MAX_LEN(4), .SIGNED(0)) dut_m (
    .clk(clk), .rst(rst), .start(m_start), .in_valid(m_valid), .in_last(m_last),
    .in_data(m_data), .in_ready(m_ready), .max_val(m_max), .min_val(m_min),
    .max_idx(m_idx), .count(m_cnt), .done(m_done));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int val(input logic [7:0] x, input bit sgn);
    return sgn ? int'({{24{x[7]}}, x}) : int'({24'b0, x});
  endfunction

  // Reference: scan the accepted prefix, keep first strict max and strict min.
  function automatic res_t model(input logic [7:0] s[$], input bit sgn, input int max_len);
    res_t r;
    int   n, best, worst, v;
    n     = (s.size() < max_len) ? s.size() : max_len;
    r.mx  = s[0];
    r.mn  = s[0];
    r.idx = 0;
    r.cnt = n;
    best  = val(s[0], sgn);
    worst = best;
    for (int i = 1; i < n; i++) begin
      v = val(s[i], sgn);
      if (v > best)  begin best = v;  r.mx = s[i]; r.idx = i; end
      if (v < worst) begin worst = v; r.mn = s[i]; end
    end
    return r;
  endfunction

  function automatic res_t mk(input logic [7:0] mx, input logic [7:0] mn, input int idx, input int cnt);
    res_t r;
    r.mx = mx; r.mn = mn; r.idx = idx; r.cnt = cnt;
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (u_done) begin
      if (qu.size() == 0) chk("u_unexpected_done", 1, 0);
      else begin
        e = qu.pop_front();
        chk("u_max", int'(u_max), int'(e.mx));
        chk("u_min", int'(u_min), int'(e.mn));
        chk("u_idx", int'(u_idx), e.idx);
        chk("u_cnt", int'(u_cnt), e.cnt);
        chk("u_ready_in_done", int'(u_ready), 0);
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (s_done) begin
      if (qs.size() == 0) chk("s_unexpected_done", 1, 0);
      else begin
        e = qs.pop_front();
        chk("s_max", int'(s_max), int'(e.mx));
        chk("s_min", int'(s_min), int'(e.mn));
        chk("s_idx", int'(s_idx), e.idx);
        chk("s_cnt", int'(s_cnt), e.cnt);
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (m_done) begin
      if (qm.size() == 0) chk("m_unexpected_done", 1, 0);
      else begin
        e = qm.pop_front();
        chk("m_max", int'(m_max), int'(e.mx));
        chk("m_min", int'(m_min), int'(e.mn));
        chk("m_idx", int'(m_idx), e.idx);
        chk("m_cnt", int'(m_cnt), e.cnt);
      end
    end
  end

  // Starts a sequence now and returns one step into the DONE cycle.
  task automatic send_seq(input logic [7:0] s[$], input bit use_last, input bit push);
    if (push) begin
      qu.push_back(model(s, 1'b0, 16));
      qs.push_back(model(s, 1'b1, 16));
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ready_after_start", int'(u_ready), 1);
    for (int i = 0; i < s.size(); i++) begin
      while ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = s[i];
      in_last  = use_last && (i == s.size() - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_u_max"},   int'(u_max), 0);
    chk({tag, "_u_min"},   int'(u_min), 0);
    chk({tag, "_u_idx"},   int'(u_idx), 0);
    chk({tag, "_u_cnt"},   int'(u_cnt), 0);
    chk({tag, "_u_done"},  int'(u_done), 0);
    chk({tag, "_u_ready"}, int'(u_ready), 0);
    chk({tag, "_s_cnt"},   int'(s_cnt), 0);
    chk({tag, "_m_ready"}, int'(m_ready), 0);
  endtask

  initial begin
    logic [7:0] s[$];
    int         len;
    bit         ul;

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    s = '{8'd3, 8'd9, 8'd9, 8'd1};
    qu.push_back(mk(8'd9, 8'd1, 1, 4));
    qs.push_back(mk(8'd9, 8'd1, 1, 4));
    send_seq(s, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    s = '{8'h80, 8'h7F, 8'hFF};
    qu.push_back(mk(8'hFF, 8'h7F, 2, 3));
    qs.push_back(mk(8'h7F, 8'h80, 1, 3));
    send_seq(s, 1'b1, 1'b0);
    @(posedge clk); #1;

    s = '{8'd5, 8'd6, 8'd4};
    qu.push_back(mk(8'd6, 8'd4, 1, 3));
    qs.push_back(mk(8'd6, 8'd4, 1, 3));
    send_seq(s, 1'b1, 1'b0);
    s = '{8'd2, 8'd8};
    qu.push_back(mk(8'd8, 8'd2, 1, 2));
    qs.push_back(mk(8'd8, 8'd2, 1, 2));
    send_seq(s, 1'b1, 1'b0);
    @(posedge clk); #1;

    s = '{8'h42};
    qu.push_back(mk(8'h42, 8'h42, 0, 1));
    qs.push_back(mk(8'h42, 8'h42, 0, 1));
    send_seq(s, 1'b1, 1'b0);
    chk("single_done_high", int'(u_done), 1);
    @(posedge clk); #1;
    chk("single_done_one_cycle", int'(u_done), 0);
    chk("single_hold_max", int'(u_max), 8'h42);
    chk("single_hold_cnt", int'(u_cnt), 1);

    // Length cap: five samples offered, only four taken.
    qm.push_back(mk(8'd20, 8'd3, 1, 4));
    m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    s = '{8'd5, 8'd20, 8'd3, 8'd7, 8'd99};
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("m_ready_%0d", i), int'(m_ready), (i < 4) ? 1 : 0);
      m_valid = 1'b1;
      m_data  = s[i];
      @(posedge clk); #1;
    end
    m_valid = 1'b0;
    chk("m_fifth_ignored_cnt", int'(m_cnt), 4);
    chk("m_fifth_ignored_max", int'(m_max), 20);

    for (int n = 0; n < 40; n++) begin
      len = $urandom_range(1, 16);
      s = {};
      for (int i = 0; i < len; i++)
        s.push_back(($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom));
      ul = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_seq(s, ul, 1'b1);
    end
    @(posedge clk); #1;

    // Reset mid-sequence discards the partial result.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd50 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_reset_cnt", int'(u_cnt), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("midrun_reset");
    in_valid = 1'b1;
    in_data  = 8'd77;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ignored_valid_cnt", int'(u_cnt), 0);
    chk("ignored_valid_max", int'(u_max), 0);
    chk("ignored_valid_ready", int'(u_ready), 0);

    repeat (4) @(posedge clk);
    #1;
    chk("u_queue_drained", qu.size(), 0);
    chk("s_queue_drained", qs.size(), 0);
    chk("m_queue_drained", qm.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
